// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared mode encodings and flat-bus indexing helper for stream_mux_nto1
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Base bit offset of channel `chan` inside a flat {chN-1, ..., ch1, ch0} bus.
    function automatic int unsigned chan_slice(input int unsigned chan, input int unsigned width);
        return chan * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first request at or after ptr, wrapping mod N
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [SEL_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        idx_s         = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_s = SEL_W'(idx);
            if (!grant_valid_o && req_i[idx_s]) begin
                grant_valid_o     = 1'b1;
                grant_idx_o       = idx_s;
                grant_oh_o[idx_s] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// rtl/stream_mux_nto1.sv - registered N-to-1 stream mux, fixed-select or round-robin
module stream_mux_nto1
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [N*WIDTH-1:0]   In_data,
    input  logic [N-1:0]         In_valid,
    output logic [N-1:0]         In_ready,
    input  logic                 Mode,
    input  logic [SEL_W-1:0]     Sel,
    output logic [WIDTH-1:0]     Out_data,
    output logic [SEL_W-1:0]     Out_chan,
    output logic                 Out_valid,
    input  logic                 Out_ready
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_chan_q,  out_chan_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    logic [N-1:0]     rr_grant_oh;
    logic [SEL_W-1:0] rr_grant_idx;
    logic             rr_grant_valid;

    logic [N-1:0]     grant_oh;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_valid;
    logic             sel_in_range;
    logic             load_en;
    logic             in_xfer;

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_arbiter (
        .req_i         (In_valid),
        .ptr_i         (ptr_q),
        .grant_oh_o    (rr_grant_oh),
        .grant_idx_o   (rr_grant_idx),
        .grant_valid_o (rr_grant_valid)
    );

    // Fixed mode decodes Sel directly; an out-of-range Sel grants nothing.
    always_comb begin
        sel_in_range = ({1'b0, Sel} < (SEL_W + 1)'(N));
        grant_oh     = '0;
        grant_idx    = '0;
        grant_valid  = 1'b0;
        if (Mode == MODE_RR) begin
            grant_oh    = rr_grant_oh;
            grant_idx   = rr_grant_idx;
            grant_valid = rr_grant_valid;
        end else if (sel_in_range && In_valid[Sel]) begin
            grant_oh[Sel] = 1'b1;
            grant_idx     = Sel;
            grant_valid   = 1'b1;
        end
    end

    assign load_en  = !out_valid_q || Out_ready;
    assign in_xfer  = Rst_n && load_en && grant_valid;
    assign In_ready = in_xfer ? grant_oh : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (in_xfer) begin
            out_data_d  = In_data[chan_slice(32'(grant_idx), WIDTH) +: WIDTH];
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (Mode == MODE_RR) begin
                ptr_d = (32'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
            end
        end else if (Out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign Out_data  = out_data_q;
    assign Out_chan  = out_chan_q;
    assign Out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// tb/tb_stream_mux_nto1.sv - directed and random scoreboard bench for stream_mux_nto1
module tb_stream_mux_nto1;

    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SEL_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_valid;
    logic               out_ready;

    int checks   = 0;
    int failures = 0;

    logic [SEL_W+WIDTH-1:0] sb_q[$];
    logic                   ov_m;
    logic [WIDTH-1:0]       ld_m;
    logic [SEL_W-1:0]       lc_m;
    int                     ptr_m;

    stream_mux_nto1 #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .In_data   (in_data),
        .In_valid  (in_valid),
        .In_ready  (in_ready),
        .Mode      (mode),
        .Sel       (sel),
        .Out_data  (out_data),
        .Out_chan  (out_chan),
        .Out_valid (out_valid),
        .Out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_grant(output int g, output bit gv);
        g  = 0;
        gv = 1'b0;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr_m + k) % N;
                if (!gv && in_valid[c]) begin
                    g  = c;
                    gv = 1'b1;
                end
            end
        end else if (in_valid[sel]) begin
            g  = int'(sel);
            gv = 1'b1;
        end
    endtask

    // One clock: check In_ready before the edge, update the model, check outputs after it.
    task automatic step();
        int         g;
        bit         gv;
        logic [3:0] er;
        logic [7:0] d;
        #1;
        model_grant(g, gv);
        er = 4'b0000;
        if (rst_n && (!ov_m || out_ready) && gv) begin
            er[g] = 1'b1;
        end
        chk("in_ready", 32'(in_ready), 32'(er));
        if (!rst_n) begin
            ov_m  = 1'b0;
            ld_m  = '0;
            lc_m  = '0;
            ptr_m = 0;
            sb_q.delete();
        end else begin
            if (ov_m && out_ready) begin
                void'(sb_q.pop_front());
                ov_m = 1'b0;
            end
            if (er != 4'b0000) begin
                d = in_data[g*WIDTH +: WIDTH];
                sb_q.push_back({SEL_W'(g), d});
                ov_m = 1'b1;
                ld_m = d;
                lc_m = SEL_W'(g);
                if (mode) ptr_m = (g + 1) % N;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(ov_m));
        chk("out_data_hold", 32'(out_data), 32'(ld_m));
        chk("out_chan_hold", 32'(out_chan), 32'(lc_m));
        if (ov_m) begin
            if (sb_q.size() == 0) begin
                chk("sb_nonempty", 32'(0), 32'(1));
            end else begin
                chk("sb_beat", 32'({out_chan, out_data}), 32'(sb_q[0]));
            end
        end
    endtask

    initial begin
        logic [7:0] rr_seq [5];
        logic [7:0] bp_seq [4];
        logic [1:0] sp_seq [3];
        rr_seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        bp_seq = '{8'h11, 8'h12, 8'h13, 8'h10};
        sp_seq = '{2'd3, 2'd1, 2'd3};
        ov_m = 1'b0; ld_m = '0; lc_m = '0; ptr_m = 0;

        // Reset with every channel valid
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_out_data", 32'(out_data), 32'(0));
        chk("reset_out_chan", 32'(out_chan), 32'(0));

        // Round-robin, all valid, full rate
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_seq", 32'(out_data), 32'(rr_seq[i]));
        end

        // Backpressure for 3 cycles, then resume
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_data", 32'(out_data), 32'h10);
            chk("bp_ready_low", 32'(in_ready), 32'(0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_resume", 32'(out_data), 32'(bp_seq[i]));
        end

        // Fixed select on ch2 while ch0 also valid
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0101;
        in_data  = {8'h00, 8'hA5, 8'h00, 8'h55};
        #1;
        chk("fix_ready", 32'(in_ready), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fix_data", 32'(out_data), 32'hA5);
            chk("fix_chan", 32'(out_chan), 32'd2);
        end

        // Sparse round-robin: steer ptr to 2, then only ch3 and ch1 request
        mode     = 1'b1;
        in_valid = 4'b0010;
        in_data  = {8'h33, 8'h22, 8'h11, 8'h00};
        step();
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sparse_chan", 32'(out_chan), 32'(sp_seq[i]));
        end

        // Idle: nothing valid, output drains and holds last data
        in_valid = 4'b0000;
        step();
        step();
        chk("idle_valid", 32'(out_valid), 32'(0));
        chk("idle_data_hold", 32'(out_data), 32'h33);

        // Mid-stream reset while a beat is held
        in_valid  = 4'b1111;
        in_data   = {8'h43, 8'h42, 8'h41, 8'h40};
        out_ready = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_valid", 32'(out_valid), 32'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk("midrst_chan0", 32'(out_chan), 32'(0));
        chk("midrst_data", 32'(out_data), 32'h40);

        // Random traffic against the scoreboard
        for (int i = 0; i < 80; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            in_data   = $urandom;
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_nto1.md
# stream_mux_nto1

Registered N-to-1 stream multiplexer. It generalises the combinational 2-to-1 select into a parametrised N-channel, W-bit datapath with valid/ready handshakes and a single-entry output register. It runs in one of two modes: fixed select, where a `Sel` port picks the channel, or round-robin arbitration across all valid inputs. It sits between multiple producer blocks and one shared consumer, such as a display or bus interface.

## Interface
- `WIDTH`, 8: data bits per channel.
- `N`, 4: number of input channels, 2 or more.
- `SEL_W`, `$clog2(N)`: width of channel index ports.

- `Clk`  in  1  rising-edge clock.
- `Rst_n`  in  1  reset, synchronous and active-low.
- `In_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `In_valid`  in  N  per-channel valid.
- `In_ready`  out  N  per-channel ready; at most one bit high per cycle.
- `Mode`  in  1  0 = fixed select, 1 = round-robin.
- `Sel`  in  SEL_W  selected channel in fixed mode; ignored in round-robin.
- `Out_data`  out  WIDTH  registered output data.
- `Out_chan`  out  SEL_W  index of the channel that supplied `Out_data`.
- `Out_valid`  out  1  output register holds a beat.
- `Out_ready`  in  1  consumer accepts.

## Operation
- Transfer on any side occurs when valid & ready are both high at a rising edge.
- Load enable: `load_en = !Out_valid | Out_ready`.
- Grant, combinational:
  - Fixed mode: grant channel `Sel` if `In_valid[Sel]`. `Sel >= N` grants nothing.
  - Round-robin: grant the first valid channel scanning ptr, ptr+1, … mod N.
- `In_ready[g] = load_en & grant_valid` for the granted g only; all other bits are 0. `In_ready` may depend combinationally on `In_valid`, `Mode`, `Sel` and `Out_ready`.
- On input transfer:
  - `Out_data` ← `In_data[g]`, `Out_chan` ← g, `Out_valid` ← 1.
  - In round-robin mode, ptr ← (g+1) mod N, with wrap from N-1 to 0.
  - In fixed mode, ptr is unchanged.
- Output transfer with no new input: `Out_valid` ← 0. `Out_data` and `Out_chan` hold their last values.
- Output transfer and input transfer in the same cycle: the register reloads. Throughput is one beat per cycle.
- Stall (`Out_valid` & !`Out_ready`): `Out_data`, `Out_chan` and `Out_valid` hold, and all `In_ready` are 0.
- `Mode` and `Sel` are sampled every cycle. Changing them never alters a beat already held in the output register.
- No beat is dropped or duplicated. Data passes through unmodified.

## Timing
- Reset values when `Rst_n` = 0 at an edge: `Out_valid`=0, `Out_data`=0, `Out_chan`=0, ptr=0. `In_ready` is forced to 0 while `Rst_n` is low.
- Reset in mid-operation discards any held beat. The first grant after reset starts from channel 0.
- Latency: an input accepted at edge k appears on `Out_data` with `Out_valid`=1 right after edge k.
- Round-robin fairness: with all N channels continuously valid and `Out_ready`=1, each channel is granted exactly once every N cycles.
- No input is granted when `In_valid`=0 everywhere, or when the selected channel is idle in fixed mode. ptr holds in both cases.

## Structure
- Shared package `stream_mux_pkg` holds `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1, plus a function `chan_slice` for indexing the flat `In_data` bus.
- Sub-module `rr_arbiter` (parameter N) takes a request vector and ptr and returns a one-hot grant, an encoded grant index and `grant_valid`. The top level owns ptr and the output register.
- Fixed mode bypasses the arbiter and decodes `Sel` directly.

## Test plan
- Reset: hold `Rst_n`=0 with all inputs valid. Then `Out_valid`=0, `Out_data`=0, `Out_chan`=0 and `In_ready`=0. Release, then the first accept comes from ch0.
- Fixed mode, N=4, `Sel`=2, ch2 sending 0xA5 and ch0 also valid: `In_ready`=4'b0100, and the next cycle shows `Out_data`=0xA5 with `Out_chan`=2. Ch0 is never taken.
- Round-robin, all 4 channels valid with data 0x10/0x11/0x12/0x13 and `Out_ready`=1: output sequence is 0x10, 0x11, 0x12, 0x13, 0x10, with one beat per cycle.
- Backpressure: hold `Out_ready`=0 for 3 cycles while `Out_valid`=1. Output stays stable, `In_ready`=0, and no beat is lost. On release, full rate resumes with no duplicates.
- Wrap and sparse requests in round-robin: only ch3 and ch1 valid, ptr=2. Grant order is ch3, then ch1 (wrap), then ch3.
- Mid-stream reset: assert `Rst_n`=0 for one cycle while a beat is held. `Out_valid` drops and ptr is 0 on the next edge.
